// File: rtl/operand_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage_if
//   Bundles every non-clock/reset signal of the operand fetch stage.
//   master : pipeline side (drives the ID instruction, register-file read data,
//            forwarding candidates and flush; observes stall and the ID/EX
//            register contents).
//   slave  : the operand fetch stage itself.
//
//   Signal summary:
//     id_*            decoded instruction presented by ID
//     rf_raddr0/1     register-file read addresses (copies of id_rs1/id_rs2)
//     rf_rdata0/1     register-file combinational read data
//     ex_alu_result   ALU result of the instruction held in the ex_* registers
//     mem_fwd_*       MEM-stage writeback candidate (load data included)
//     wb_fwd_*        WB-stage write (same values as register-file write port)
//     flush           branch/jump redirect, kills the ID instruction
//     stall_id        hold PC and IF/ID this cycle
//     ex_*            ID/EX pipeline register contents
// ----------------------------------------------------------------------------
interface operand_fetch_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;

  logic [REG_AW-1:0] rf_raddr0;
  logic [REG_AW-1:0] rf_raddr1;
  logic [XLEN-1:0]   rf_rdata0;
  logic [XLEN-1:0]   rf_rdata1;

  logic [XLEN-1:0]   ex_alu_result;

  logic              mem_fwd_valid;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [XLEN-1:0]   mem_fwd_data;

  logic              wb_fwd_valid;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;

  logic              flush;
  logic              stall_id;

  logic              ex_valid;
  logic [XLEN-1:0]   ex_rs1_val;
  logic [XLEN-1:0]   ex_rs2_val;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rd_we;
  logic              ex_is_load;
  logic [XLEN-1:0]   ex_imm;
  logic [XLEN-1:0]   ex_pc;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_rd_we,
           id_is_load, id_imm, id_pc,
    output rf_rdata0, rf_rdata1, ex_alu_result,
    output mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
    output wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    output flush,
    input  rf_raddr0, rf_raddr1, stall_id,
    input  ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_is_load,
           ex_imm, ex_pc
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_rd_we,
           id_is_load, id_imm, id_pc,
    input  rf_rdata0, rf_rdata1, ex_alu_result,
    input  mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
    input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
    input  flush,
    output rf_raddr0, rf_raddr1, stall_id,
    output ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_is_load,
           ex_imm, ex_pc
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage
//   ID-to-EX boundary of the RV32I pipeline. Reads both register-file ports,
//   resolves RAW hazards by bypassing from EX, MEM and WB, detects load-use
//   hazards (one-cycle ID stall plus a bubble) and registers operands and
//   control into the ID/EX register.
//
//   Ports:
//     clk  : clock, all state updates on the rising edge
//     rst  : asynchronous active-high reset, clears the ID/EX register
//     bus  : operand_fetch_stage_if.slave (ID instruction, register-file read
//            port, forwarding sources, flush, stall and ID/EX outputs)
// ----------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_fetch_stage_if.slave  bus
);

  // ID/EX pipeline register
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_rs1_val;
  logic [XLEN-1:0]   r_ex_rs2_val;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_rd_we;
  logic              r_ex_is_load;
  logic [XLEN-1:0]   r_ex_imm;
  logic [XLEN-1:0]   r_ex_pc;

  logic              w_hazard;
  logic              w_ex_is_live_load;

  // The instruction in EX can only be bypassed once its ALU result exists,
  // i.e. when it is not a load; a load's data arrives one stage later.
  logic              w_ex_fwd_ok;
  assign w_ex_fwd_ok       = r_ex_valid & r_ex_rd_we & ~r_ex_is_load;
  assign w_ex_is_live_load = r_ex_valid & r_ex_is_load & r_ex_rd_we &
                             (r_ex_rd != '0);

  // One operand-select / hazard-detect slice per source register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [REG_AW-1:0] w_idx;
      logic              w_uses;
      logic [XLEN-1:0]   w_rf_data;
      logic [XLEN-1:0]   w_op_val;
      logic              w_load_dep;

      assign w_idx     = (gi == 0) ? bus.id_rs1      : bus.id_rs2;
      assign w_uses    = (gi == 0) ? bus.id_uses_rs1 : bus.id_uses_rs2;
      assign w_rf_data = (gi == 0) ? bus.rf_rdata0   : bus.rf_rdata1;

      // Youngest producer wins. Because x0 is tested first, a forwarding
      // source targeting x0 can never supply a value.
      always_comb begin
        w_op_val = w_rf_data;
        if (w_idx == '0) begin
          w_op_val = '0;
        end else if (w_ex_fwd_ok && (r_ex_rd == w_idx)) begin
          w_op_val = bus.ex_alu_result;
        end else if (bus.mem_fwd_valid && (bus.mem_fwd_rd == w_idx)) begin
          w_op_val = bus.mem_fwd_data;
        end else if (bus.wb_fwd_valid && (bus.wb_fwd_rd == w_idx)) begin
          // Register file only commits at the edge, so write through here.
          w_op_val = bus.wb_fwd_data;
        end
      end

      // Sources the instruction does not actually read never stall.
      assign w_load_dep = w_uses & (r_ex_rd == w_idx);
    end
  endgenerate

  assign w_hazard = bus.id_valid & w_ex_is_live_load &
                    (g_src[0].w_load_dep | g_src[1].w_load_dep);

  // A redirect must never be blocked by a stall on the instruction it kills.
  assign bus.stall_id  = w_hazard & ~bus.flush;
  assign bus.rf_raddr0 = bus.id_rs1;
  assign bus.rf_raddr1 = bus.id_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_rs1_val <= '0;
      r_ex_rs2_val <= '0;
      r_ex_rd      <= '0;
      r_ex_rd_we   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_ex_imm     <= '0;
      r_ex_pc      <= '0;
    end else if (bus.flush) begin
      // Payload fields hold; only validity matters downstream.
      r_ex_valid <= 1'b0;
    end else if (w_hazard) begin
      // Bubble: ID keeps the instruction and reissues it next cycle.
      r_ex_valid   <= 1'b0;
      r_ex_rd_we   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else begin
      r_ex_valid   <= bus.id_valid;
      r_ex_rd_we   <= bus.id_rd_we & bus.id_valid;
      r_ex_is_load <= bus.id_is_load;
      r_ex_rd      <= bus.id_rd;
      r_ex_imm     <= bus.id_imm;
      r_ex_pc      <= bus.id_pc;
      r_ex_rs1_val <= g_src[0].w_op_val;
      r_ex_rs2_val <= g_src[1].w_op_val;
    end
  end

  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_rs1_val = r_ex_rs1_val;
  assign bus.ex_rs2_val = r_ex_rs2_val;
  assign bus.ex_rd      = r_ex_rd;
  assign bus.ex_rd_we   = r_ex_rd_we;
  assign bus.ex_is_load = r_ex_is_load;
  assign bus.ex_imm     = r_ex_imm;
  assign bus.ex_pc      = r_ex_pc;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID-to-EX boundary stage of the pipelined RV32I core.
- Consumes the two combinational read ports of the 32x32 register file and resolves RAW hazards by bypassing results from EX, MEM and WB.
- Detects load-use hazards and stalls ID for one cycle.
- Registers operands plus control into the ID/EX pipeline register consumed by the ALU.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source register 1 index
id_rs2  in  REG_AW  source register 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_AW  destination index
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
id_imm  in  XLEN  decoded immediate
id_pc  in  XLEN  instruction PC
rf_raddr0  out  REG_AW  register-file read address 0 (= id_rs1)
rf_raddr1  out  REG_AW  register-file read address 1 (= id_rs2)
rf_rdata0  in  XLEN  register-file read data 0
rf_rdata1  in  XLEN  register-file read data 1
ex_alu_result  in  XLEN  combinational ALU result of instruction currently in ex_* registers
mem_fwd_valid / mem_fwd_rd / mem_fwd_data  in  1 / REG_AW / XLEN  MEM-stage writeback candidate (load data included)
wb_fwd_valid / wb_fwd_rd / wb_fwd_data  in  1 / REG_AW / XLEN  WB-stage write (same values driven to register-file we/waddr/wdata)
flush  in  1  branch/jump redirect; kill ID instruction
stall_id  out  1  hold PC and IF/ID this cycle
ex_valid, ex_rs1_val, ex_rs2_val, ex_rd, ex_rd_we, ex_is_load, ex_imm, ex_pc  out  ID/EX register contents

Behaviour:
- Reset (async, rst=1): all ex_* outputs = 0 immediately, including ex_valid=0. stall_id=0 while rst=1.
- rf_raddr0/1: combinational copies of id_rs1/id_rs2.
- Operand select, per source independently, first match wins:
  - index==0 -> 0.
  - ex_valid & ex_rd_we & ex_rd==rs & !ex_is_load -> ex_alu_result.
  - mem_fwd_valid & mem_fwd_rd==rs -> mem_fwd_data.
  - wb_fwd_valid & wb_fwd_rd==rs -> wb_fwd_data (write-through: register file updates only at the edge).
  - otherwise rf_rdata.
- A forwarding source with rd==0 never matches.
- Load-use hazard: hazard = id_valid & ex_valid & ex_is_load & ex_rd_we & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- stall_id = hazard & !flush (combinational).
- Edge update, priority order:
  - flush: ex_valid<=0; other ex_* fields don't-care (hold).
  - else hazard: bubble; ex_valid<=0, ex_rd_we<=0, ex_is_load<=0. ID contents held upstream.
  - else: ex_valid<=id_valid; ex_rd_we<=id_rd_we & id_valid; other fields captured from ID and the selected operands.
- Latency: 1 cycle ID->EX. Load-use costs exactly 1 bubble; next cycle the load sits in MEM and its data is forwarded via mem_fwd.
- Unused sources (id_uses_rsX=0) never cause stalls; their operand value is still captured.
- Simultaneous flush and hazard: flush wins; stall_id=0 so the fetch redirect is not blocked.
- Reset mid-stall: state clears; first post-reset cycle sees ex_valid=0, so no stall.

Test Plan:
- RF read: x5=0x1234 in register file, no forwarding; issue add rs1=5 rs2=0 -> next cycle ex_rs1_val=0x1234, ex_rs2_val=0, ex_valid=1.
- Priority: ex writes x7 via ALU 0xA, mem_fwd x7=0xB, wb_fwd x7=0xC; ID reads x7 -> ex_rs1_val=0xA. Drop EX match -> 0xB; drop MEM match -> 0xC.
- x0 guard: wb_fwd_valid=1, rd=0, data=0xFFFF_FFFF; ID reads x0 -> operand 0.
- Load-use: lw x3 in EX; ID add x4,x3,x1 -> stall_id=1 for exactly one cycle and ex_valid=0 bubble. Next cycle mem_fwd x3=0x55 -> ex_rs1_val=0x55.
- No false stall: load to x3 in EX, ID uses rs2=3 with id_uses_rs2=0 -> stall_id=0. Load to x0 in EX with rs1=0 -> stall_id=0.
- Flush with hazard asserted -> stall_id=0, next ex_valid=0. Assert rst mid-stream -> ex_* cleared asynchronously before the next edge.
